// File: rtl/spike_packetizer.sv
// Serialises each captured spike vector into 32-bit packets {node, tag, index}
// and offers them through a first-word-fall-through FIFO with valid/ready.
module spike_packetizer #(
   parameter int         NUM_NEURONS = 4,
   parameter logic [7:0] NODE_ID     = 8'h00,
   parameter int         FIFO_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_NEURONS-1:0]         spike_vec,
   input  logic                           spike_valid,
   output logic                           busy,
   output logic                           drop_flag,
   input  logic                           drop_clear,
   output logic [31:0]                    pkt_data,
   output logic                           pkt_valid,
   input  logic                           pkt_ready,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic [7:0]                     timestep
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                 state;
   logic [NUM_NEURONS-1:0] shadow;
   logic [NUM_NEURONS-1:0] low_bit;
   logic [NUM_NEURONS-1:0] rest;
   logic [7:0]             tag;
   logic [15:0]            idx;
   logic [31:0]            push_word;
   logic [31:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW-1:0]          rd_next;
   logic [CW-1:0]          count;
   logic [CW-1:0]          count_next;
   logic [31:0]            head_next;
   logic                   full;
   logic                   push;
   logic                   pop;

   // Isolate the lowest set bit; the remainder decides when the scan ends.
   always_comb begin
      low_bit = shadow & (~shadow + NUM_NEURONS'(1));
      rest    = shadow & ~low_bit;
   end

   always_comb begin
      idx = '0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (shadow[i]) idx = 16'(i);
      end
   end

   assign push_word  = {NODE_ID, tag, idx};
   assign full       = (count == CW'(FIFO_DEPTH));
   assign pkt_valid  = (count != '0);
   assign push       = (state == SCAN) && !full;
   assign pop        = pkt_valid && pkt_ready;
   assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
   assign fifo_count = count;

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Registered head: a freshly pushed word becomes head when nothing older remains.
   always_comb begin
      head_next = pkt_data;
      if (count_next != '0) begin
         if (count == '0 || (pop && count == CW'(1)))
            head_next = push_word;
         else
            head_next = mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pkt_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr   <= rd_next;
         count    <= count_next;
         pkt_data <= head_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         shadow    <= '0;
         tag       <= '0;
         timestep  <= '0;
         drop_flag <= 1'b0;
      end else begin
         if (state == SCAN && spike_valid)
            drop_flag <= 1'b1;
         else if (drop_clear)
            drop_flag <= 1'b0;

         unique case (state)
            IDLE: begin
               if (spike_valid) begin
                  shadow   <= spike_vec;
                  tag      <= timestep;
                  timestep <= timestep + 8'd1;
                  if (spike_vec != '0) begin
                     state <= SCAN;
                     busy  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (push) begin
                  shadow <= rest;
                  if (rest == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer: scan order, back-pressure, drops,
// timestep wrap and asynchronous reset.
module tb_spike_packetizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] spike_vec;
   logic        spike_valid;
   logic        busy;
   logic        drop_flag;
   logic        drop_clear;
   logic [31:0] pkt_data;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [3:0]  fifo_count;
   logic [7:0]  timestep;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rx [$];

   spike_packetizer #(
      .NUM_NEURONS(16),
      .NODE_ID    (8'h00),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spike_vec  (spike_vec),
      .spike_valid(spike_valid),
      .busy       (busy),
      .drop_flag  (drop_flag),
      .drop_clear (drop_clear),
      .pkt_data   (pkt_data),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .fifo_count (fifo_count),
      .timestep   (timestep)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && pkt_valid && pkt_ready) rx.push_back(pkt_data);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_valid"}, 32'(pkt_valid),  32'd0);
      check({tag, "_drop"},  32'(drop_flag),  32'd0);
      check({tag, "_count"}, 32'(fifo_count), 32'd0);
      check({tag, "_ts"},    32'(timestep),   32'd0);
      check({tag, "_data"},  pkt_data,        32'd0);
   endtask

   initial begin
      int cyc;
      rst         = 1'b1;
      spike_vec   = '0;
      spike_valid = 1'b0;
      drop_clear  = 1'b0;
      pkt_ready   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // basic scan of 4'b1010
      pkt_ready   = 1'b1;
      spike_vec   = 16'h000A;
      spike_valid = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      check("basic_busy_n",  32'(busy),      32'd1);
      check("basic_ts",      32'(timestep),  32'd1);
      check("basic_valid_n", 32'(pkt_valid), 32'd0);
      @(negedge clk);
      check("basic_busy_n1", 32'(busy),      32'd1);
      check("basic_head0",   pkt_data,       32'h0000_0001);
      @(negedge clk);
      check("basic_busy_n2", 32'(busy),      32'd0);
      check("basic_head1",   pkt_data,       32'h0000_0003);
      @(negedge clk);
      check("basic_empty",   32'(pkt_valid), 32'd0);
      check("basic_hold",    pkt_data,       32'h0000_0003);
      check("basic_rx_n",    32'(rx.size()), 32'd2);
      check("basic_rx0",     rx[0],          32'h0000_0001);
      check("basic_rx1",     rx[1],          32'h0000_0003);
      rx.delete();

      // back-pressure with all 16 neurons firing
      pkt_ready   = 1'b0;
      spike_vec   = 16'hFFFF;
      spike_valid = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("bp_count", 32'(fifo_count), 32'd8);
      check("bp_busy",  32'(busy),       32'd1);
      check("bp_head",  pkt_data,        32'h0001_0000);

      // drop while busy
      spike_vec   = 16'h0001;
      spike_valid = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      check("drop_set", 32'(drop_flag), 32'd1);
      check("drop_ts",  32'(timestep),  32'd2);
      drop_clear = 1'b1;
      @(negedge clk);
      drop_clear = 1'b0;
      check("drop_clr", 32'(drop_flag), 32'd0);
      spike_valid = 1'b1;
      drop_clear  = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      drop_clear  = 1'b0;
      check("drop_set_wins", 32'(drop_flag), 32'd1);
      drop_clear = 1'b1;
      @(negedge clk);
      drop_clear = 1'b0;
      check("drop_clr2", 32'(drop_flag), 32'd0);

      // pop while full: the push is blocked this cycle
      pkt_ready = 1'b1;
      @(negedge clk);
      check("full_pop_count", 32'(fifo_count), 32'd7);
      check("full_pop_head",  pkt_data,        32'h0001_0001);
      cyc = 0;
      while ((busy || pkt_valid) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("bp_drained", 32'(busy | pkt_valid), 32'd0);
      check("bp_rx_n",    32'(rx.size()),        32'd16);
      for (int i = 0; i < 16; i++)
         check($sformatf("bp_rx%0d", i), rx[i], {16'h0001, 16'(i)});
      rx.delete();

      // all-zero vectors and timestep wrap
      spike_vec   = '0;
      spike_valid = 1'b1;
      @(negedge clk);
      check("zero_busy",  32'(busy),      32'd0);
      check("zero_valid", 32'(pkt_valid), 32'd0);
      check("zero_ts",    32'(timestep),  32'd3);
      repeat (252) @(negedge clk);
      check("zero_ts255", 32'(timestep),  32'd255);
      @(negedge clk);
      spike_valid = 1'b0;
      check("zero_wrap",  32'(timestep),  32'd0);
      check("zero_rx_n",  32'(rx.size()), 32'd0);

      // asynchronous reset mid-drain
      pkt_ready   = 1'b0;
      spike_vec   = 16'hFFFF;
      spike_valid = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("ar_count", 32'(fifo_count), 32'd5);
      check("ar_busy",  32'(busy),       32'd1);
      #2 rst = 1'b1;
      #1 check_idle_outputs("async");
      @(negedge clk);
      rst       = 1'b0;
      pkt_ready = 1'b1;
      spike_vec   = 16'h0001;
      spike_valid = 1'b1;
      @(negedge clk);
      spike_valid = 1'b0;
      @(negedge clk);
      check("post_valid", 32'(pkt_valid), 32'd1);
      check("post_data",  pkt_data,       32'h0000_0000);
      @(negedge clk);
      check("post_rx_n",  32'(rx.size()), 32'd1);
      check("post_empty", 32'(pkt_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_packetizer.md
Name: spike_packetizer

Overview:
- Sits directly downstream of neuron_bank.
- After each neuron update timestep, it takes the per-neuron spike flags and serialises every spiking neuron into a 32-bit spike packet.
- Packets are buffered in a FIFO and offered to the network interface over a valid/ready handshake.
- A single timestep's spikes drain at one packet per cycle. Back-pressure stalls the scan; it never drops packets.

Parameters:
- NUM_NEURONS, 4, number of neurons in the attached bank (1..65536).
- NODE_ID, 0, 8-bit ID of this NoC node, inserted into every packet.
- FIFO_DEPTH, 8, packet FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- spike_vec  input  NUM_NEURONS  spike flags; bit i = neuron i fired this timestep.
- spike_valid  input  1  one-cycle strobe; spike_vec is valid.
- busy  output  1  high while a captured vector is being scanned.
- drop_flag  output  1  sticky; a spike_valid arrived while busy.
- drop_clear  input  1  clears drop_flag.
- pkt_data  output  32  head-of-FIFO packet.
- pkt_valid  output  1  FIFO not empty.
- pkt_ready  input  1  consumer accepts pkt_data this cycle.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
- timestep  output  8  count of accepted spike vectors, wraps 255→0.

Behaviour:
- Reset (async, immediate): state IDLE, shadow register 0, FIFO empty. busy, pkt_valid, drop_flag, fifo_count, timestep and pkt_data all 0. Reset mid-scan or mid-drain discards all pending spikes and packets.
- Packet format:
  - [31:24] NODE_ID
  - [23:16] timestep tag
  - [15:0] neuron index, zero-extended
- FSM IDLE:
  - On spike_valid=1: latch spike_vec into the shadow register and latch tag=timestep. timestep increments the same edge.
  - If spike_vec≠0, go to SCAN; otherwise stay in IDLE. The timestep still increments on an all-zero vector.
- FSM SCAN:
  - Each cycle, a priority encoder selects the lowest set shadow bit.
  - If the FIFO is not full: push {NODE_ID, tag, index} and clear that bit.
  - If the FIFO is full: hold; nothing is cleared.
  - Leave for IDLE on the edge that clears the last set bit.
- busy = (state==SCAN); it is registered.
- Latency: spike_valid sampled at edge N. The first packet is pushed at edge N+1, so pkt_valid=1 after N+1 if the FIFO was empty. Peak rate is one packet per cycle.
- spike_valid while busy: the vector is ignored, timestep does not increment, and drop_flag is set at that edge.
- drop_flag: drop_clear=1 clears it. If set and clear occur in the same cycle, set wins.
- FIFO:
  - First-word-fall-through; pkt_data = head entry whenever pkt_valid=1.
  - Pop occurs when pkt_valid && pkt_ready.
  - Full is evaluated on the current count. A push is blocked when full even if a pop happens the same cycle; that push succeeds the next cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - pkt_ready while empty has no effect.
  - pkt_data holds its last value when the FIFO is empty.
- Spikes always leave in ascending neuron index order within a timestep. Packets of consecutive timesteps never interleave.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0.
- Basic scan, NUM_NEURONS=4, pkt_ready=1: spike_vec=4'b1010, spike_valid at edge N → busy high for N+1..N+2; packets 0x00000001 then 0x00000003; timestep=1.
- Back-pressure: pkt_ready=0, FIFO_DEPTH=8, NUM_NEURONS=16, vec=16'hFFFF → fifo_count saturates at 8 and busy stays 1. Then pkt_ready=1 → all 16 packets arrive, indices 0..15 in order, none lost.
- Drop: issue spike_valid during SCAN → drop_flag=1 and timestep unchanged. drop_clear → 0.
- Empty vector: spike_valid with vec=0 → busy stays 0, no packet, timestep increments. 256 such strobes → timestep wraps to 0.
- Async reset mid-drain: assert rst with fifo_count=5 and busy=1 → outputs clear immediately, without waiting for a clock edge. A later vector 4'b0001 → packet 0x00000000 (tag 0).
